// File: rtl/counter_monitor.sv
// rtl/counter_monitor.sv - passive up-count sequence monitor with lock, error and wrap tracking
// Optional feature macro: COUNTER_MONITOR_RESYNC_EN (reacquire after a mismatch instead of faulting)
module counter_monitor #(
  parameter int Size       = 5,
  parameter int LockCycles = 2,
  parameter int ErrWidth   = 8,
  parameter int WrapWidth  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [Size-1:0]      count,
  output logic                 locked,
  output logic                 error,
  output logic                 fault,
  output logic [ErrWidth-1:0]  error_count,
  output logic [WrapWidth-1:0] wrap_count,
  output logic [Size-1:0]      first_bad,
  output logic [Size-1:0]      expected
);

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam logic [Size-1:0]      CountOne = Size'(1);
  localparam logic [ErrWidth-1:0]  ErrOne   = ErrWidth'(1);
  localparam logic [WrapWidth-1:0] WrapOne  = WrapWidth'(1);
  localparam logic [3:0]           LockTgt  = 4'(LockCycles);

  state_t               state_q, state_d;
  logic [Size-1:0]      prev_q, prev_d;
  logic [3:0]           match_q, match_d;
  logic                 locked_q, locked_d;
  logic                 error_q, error_d;
  logic                 fault_q, fault_d;
  logic [ErrWidth-1:0]  err_cnt_q, err_cnt_d;
  logic [WrapWidth-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [Size-1:0]      first_bad_q, first_bad_d;
  logic [Size-1:0]      expected_q, expected_d;

  // Next-state and next-output decode; nothing moves unless a sample is taken
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_d     = match_q;
    error_d     = 1'b0;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;
    first_bad_d = first_bad_q;
    expected_d  = expected_q;
    if (enable) begin
      case (state_q)
        UNSYNC: begin
          prev_d     = count;
          match_d    = 4'd0;
          expected_d = count + CountOne;
          state_d    = ACQUIRE;
        end
        ACQUIRE: begin
          if (count == prev_q + CountOne) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 >= LockTgt) state_d = LOCKED;
          end else begin
            match_d = 4'd0;
          end
          prev_d     = count;
          expected_d = count + CountOne;
        end
        LOCKED: begin
          if (count == expected_q) begin
            if (prev_q == '1 && count == '0) wrap_cnt_d = wrap_cnt_q + WrapOne;
            prev_d     = count;
            expected_d = count + CountOne;
          end else begin
            error_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ErrOne;
            if (err_cnt_q == '0) first_bad_d = count;
`ifdef COUNTER_MONITOR_RESYNC_EN
            prev_d     = count;
            match_d    = 4'd0;
            expected_d = count + CountOne;
            state_d    = ACQUIRE;
`else
            state_d    = FAULT;
`endif
          end
        end
        default: begin
          // FAULT: samples are ignored until reset
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
`ifdef COUNTER_MONITOR_RESYNC_EN
    fault_d  = 1'b0;
`else
    fault_d  = (state_d == FAULT);
`endif
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= UNSYNC;
      prev_q      <= '0;
      match_q     <= 4'd0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
      fault_q     <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
      first_bad_q <= '0;
      expected_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
      fault_q     <= fault_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
      first_bad_q <= first_bad_d;
      expected_q  <= expected_d;
    end
  end

  assign locked      = locked_q;
  assign error       = error_q;
  assign fault       = fault_q;
  assign error_count = err_cnt_q;
  assign wrap_count  = wrap_cnt_q;
  assign first_bad   = first_bad_q;
  assign expected    = expected_q;

endmodule

// File: tb/tb_counter_monitor.sv
// tb/tb_counter_monitor.sv - randomized and directed bench for counter_monitor against a behavioural model
module tb_counter_monitor;

  localparam int SIZE  = 5;
  localparam int LOCKC = 2;
  localparam int EW    = 8;
  localparam int WW    = 8;
  localparam int M     = 1 << SIZE;
  localparam int EMAX  = (1 << EW) - 1;
  localparam int WM    = 1 << WW;

  logic            clock = 1'b0;
  logic            rst   = 1'b1;
  logic            en    = 1'b0;
  logic [SIZE-1:0] cnt   = '0;
  logic            locked, error, fault;
  logic [EW-1:0]   error_count;
  logic [WW-1:0]   wrap_count;
  logic [SIZE-1:0] first_bad, expected;

  counter_monitor #(.Size(SIZE), .LockCycles(LOCKC), .ErrWidth(EW), .WrapWidth(WW)) dut (
    .clock(clock), .reset(rst), .enable(en), .count(cnt),
    .locked(locked), .error(error), .fault(fault),
    .error_count(error_count), .wrap_count(wrap_count),
    .first_bad(first_bad), .expected(expected)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: flags and integers describing what has been observed
  bit m_seen, m_locked, m_dead, m_error;
  int m_prev, m_streak, m_ec, m_wc, m_fb, m_exp;

  always @(posedge clock) begin
    if (rst) begin
      m_seen = 0; m_locked = 0; m_dead = 0; m_error = 0;
      m_prev = 0; m_streak = 0; m_ec = 0; m_wc = 0; m_fb = 0; m_exp = 0;
    end else begin
      m_error = 0;
      if (en && !m_dead) begin
        if (!m_seen) begin
          m_seen = 1; m_prev = int'(cnt); m_streak = 0; m_exp = (int'(cnt) + 1) % M;
        end else if (!m_locked) begin
          if (int'(cnt) == (m_prev + 1) % M) m_streak++;
          else m_streak = 0;
          if (m_streak >= LOCKC) m_locked = 1;
          m_prev = int'(cnt); m_exp = (int'(cnt) + 1) % M;
        end else if (int'(cnt) == m_exp) begin
          if (cnt == 0) m_wc = (m_wc + 1) % WM;
          m_prev = int'(cnt); m_exp = (int'(cnt) + 1) % M;
        end else begin
          m_error = 1;
          if (m_ec == 0) m_fb = int'(cnt);
          m_ec = (m_ec < EMAX) ? m_ec + 1 : EMAX;
          m_locked = 0;
`ifdef COUNTER_MONITOR_RESYNC_EN
          m_streak = 0; m_prev = int'(cnt); m_exp = (int'(cnt) + 1) % M;
`else
          m_dead = 1;
`endif
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clock) begin
    if (checking) begin
      check("locked",      locked,      m_locked);
      check("error",       error,       m_error);
      check("fault",       fault,       m_dead);
      check("error_count", error_count, m_ec);
      check("wrap_count",  wrap_count,  m_wc);
      check("first_bad",   first_bad,   m_fb);
      check("expected",    expected,    m_exp);
    end
  end

  task automatic cyc(input bit r, input bit e, input int c);
    @(negedge clock);
    rst = r; en = e; cnt = SIZE'(c);
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input int from, input int to);
    for (int v = from; v <= to; v++) cyc(0, 1, v % M);
  endtask

  initial begin
    int last;
    int c;
    bit r, e;

    // Reset state
    cyc(1, 0, 0);
    cyc(1, 1, 17);
    checking = 1'b1;
    check("rst_locked", locked, 0);
    check("rst_err_cnt", error_count, 0);
    check("rst_expected", expected, 0);

    // Lock onto 0,1,2,3
    feed(0, 3);
    check("lock_locked", locked, 1);
    check("lock_expected", expected, 4);
    check("lock_err_cnt", error_count, 0);

    // Clean run through two wraps
    feed(4, 64);
    check("run_wraps", wrap_count, 2);
    check("run_locked", locked, 1);

    // Mismatch while locked at 9
    cyc(1, 0, 0);
    feed(0, 9);
    cyc(0, 1, 12);
    check("mm_error", error, 1);
    check("mm_err_cnt", error_count, 1);
    check("mm_first_bad", first_bad, 12);
`ifdef COUNTER_MONITOR_RESYNC_EN
    feed(13, 15);
    check("rs_err_cnt", error_count, 1);
    check("rs_first_bad", first_bad, 12);
    check("rs_locked", locked, 1);
    check("rs_fault", fault, 0);
`else
    check("mm_fault", fault, 1);
    check("mm_locked", locked, 0);
    cyc(0, 1, 3);
    cyc(0, 1, 4);
    check("mm_err_pulse", error, 0);
    check("mm_err_cnt_hold", error_count, 1);
    check("mm_first_bad_hold", first_bad, 12);
`endif

    // Reset from the post-mismatch state
    cyc(1, 1, 5);
    check("rst2_err_cnt", error_count, 0);
    check("rst2_first_bad", first_bad, 0);
    check("rst2_fault", fault, 0);

    // Disabled gap with count jumping around
    cyc(0, 0, 0);
    feed(0, 7);
    for (int i = 0; i < 5; i++) cyc(0, 0, 7 + 3 * (i + 1));
    cyc(0, 1, 8);
    check("gap_error", error, 0);
    check("gap_locked", locked, 1);
    check("gap_expected", expected, 9);

    // Randomized traffic
    last = 8;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 149) == 0);
      e = ($urandom_range(0, 3) != 0);
      if (e) begin
        c = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, M - 1)) : (last + 1) % M;
        last = c;
      end else begin
        c = int'($urandom_range(0, M - 1));
      end
      cyc(r, e, c);
    end

    @(negedge clock);
    #1;
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
